// File: rtl/fila_pkg.sv
// Shared definitions for the byte queue and its serializing consumer.
package fila_pkg;

  localparam int DATA_W      = 8;
  localparam int QUEUE_DEPTH = 8;
  localparam int MAX_WAIT    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fila_serializador_if.sv
// Bundle between the queue, the serializer and the downstream serial sink.
// master = serializer side, slave = queue/sink side.
interface fila_serializador_if #(
  parameter int DATA_W = fila_pkg::DATA_W
);

  logic [7:0]        len_in;
  logic [DATA_W-1:0] data_in;
  logic              ready_in;
  logic              dequeue_out;
  logic              serial_out;
  logic              valid_out;
  logic              done_out;

  modport master (
    input  len_in, data_in, ready_in,
    output dequeue_out, serial_out, valid_out, done_out
  );

  modport slave (
    output len_in, data_in, ready_in,
    input  dequeue_out, serial_out, valid_out, done_out
  );

endinterface

// File: rtl/fila_serializador_shift_tx.sv
// Shift register and bit counter: loads a captured byte and shifts it out
// MSB-first, one bit per accepted valid/ready beat.
module fila_serializador_shift_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clock_10KHz,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              active,
  input  logic              ready,
  output logic              serial,
  output logic              last_accept
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              accept;

  assign accept      = active & ready;
  assign serial      = shreg[DATA_W-1];
  assign last_accept = accept & (bit_cnt == {CNT_W{1'b0}});

  // Load on capture, shift left and count down on each accepted bit, else hold.
  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      shreg   <= {DATA_W{1'b0}};
      bit_cnt <= {CNT_W{1'b0}};
    end else if (load) begin
      shreg   <= data;
      bit_cnt <= CNT_W'(DATA_W - 1);
    end else if (accept) begin
      shreg   <= shreg << 1;
      bit_cnt <= bit_cnt - CNT_W'(1);
    end else begin
      shreg   <= shreg;
      bit_cnt <= bit_cnt;
    end
  end

endmodule

// File: rtl/fila_serializador.sv
// Queue consumer: pulses dequeue, confirms the pop by a length decrement,
// captures the byte and hands it to the shifter. Retries a dropped pop.
module fila_serializador
  import fila_pkg::*;
#(
  parameter int DATA_W   = fila_pkg::DATA_W,
  parameter int MAX_WAIT = fila_pkg::MAX_WAIT
) (
  input  logic                clock_10KHz,
  input  logic                reset,
  fila_serializador_if.master bus
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  // Leaving WAIT on this count means MAX_WAIT WAIT cycles have elapsed.
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        len_prev;
  logic [WCNT_W-1:0] wait_cnt;
  logic              pop_seen;
  logic              load;
  logic              shift_en;
  logic              shift_bit;
  logic              last_accept;

  // The queue moves by at most one per edge and only a dequeue shrinks it.
  assign pop_seen = bus.len_in < len_prev;

  fila_serializador_shift_tx #(.DATA_W(DATA_W)) u_shift_tx (
    .clock_10KHz (clock_10KHz),
    .reset       (reset),
    .load        (load),
    .data        (bus.data_in),
    .active      (shift_en),
    .ready       (bus.ready_in),
    .serial      (shift_bit),
    .last_accept (last_accept)
  );

  // FSM state register and previous-length tracker.
  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      len_prev <= 8'd0;
    end else begin
      state    <= state_next;
      len_prev <= bus.len_in;
    end
  end

  // Pop-confirmation timeout counter: cleared in POP, counts through WAIT.
  always_ff @(posedge clock_10KHz or posedge reset) begin
    if (reset) begin
      wait_cnt <= {WCNT_W{1'b0}};
    end else if (state == POP) begin
      wait_cnt <= {WCNT_W{1'b0}};
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + WCNT_W'(1);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Next-state and Moore outputs decoded from the state register.
  always_comb begin
    state_next      = state;
    load            = 1'b0;
    shift_en        = 1'b0;
    bus.dequeue_out = 1'b0;
    bus.valid_out   = 1'b0;
    bus.serial_out  = 1'b0;
    bus.done_out    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.len_in != 8'd0) begin
          state_next = POP;
        end else begin
          state_next = IDLE;
        end
      end
      POP: begin
        bus.dequeue_out = 1'b1;
        state_next      = WAIT;
      end
      WAIT: begin
        if (pop_seen) begin
          load       = 1'b1;
          state_next = SHIFT;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      SHIFT: begin
        shift_en       = 1'b1;
        bus.valid_out  = 1'b1;
        bus.serial_out = shift_bit;
        if (last_accept) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE: begin
        bus.done_out = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fila_serializador.sv
// Bench for fila_serializador: behavioural 8-entry queue (pop applied two
// edges after the dequeue pulse, enqueue wins a collision), byte scoreboard
// filled by the stimulus and drained by an independent output monitor.
module tb_fila_serializador;

  logic clock_10KHz = 1'b0;
  logic reset       = 1'b1;

  always #50 clock_10KHz = ~clock_10KHz;

  fila_serializador_if bus ();

  fila_serializador dut (
    .clock_10KHz (clock_10KHz),
    .reset       (reset),
    .bus         (bus)
  );

  // ---------------- queue model ----------------
  logic [7:0] mem [0:7];
  logic [2:0] head     = 3'd0;
  logic [2:0] tail     = 3'd0;
  logic [7:0] q_len    = 8'd0;
  logic [7:0] q_data   = 8'd0;
  logic       deq_pend = 1'b0;
  logic       enq      = 1'b0;
  logic [7:0] enq_data = 8'd0;
  logic       ready    = 1'b1;
  int         cyc      = 0;

  assign bus.len_in   = q_len;
  assign bus.data_in  = q_data;
  assign bus.ready_in = ready;

  // Queue: dequeue request registered, applied one edge later unless an enqueue wins.
  always @(posedge clock_10KHz) begin
    deq_pend <= bus.dequeue_out && !enq;
    if (enq && q_len < 8'd8) begin
      mem[tail] <= enq_data;
      tail      <= tail + 3'd1;
      q_len     <= q_len + 8'd1;
    end else if (deq_pend && q_len != 8'd0) begin
      q_data <= mem[head];
      head   <= head + 3'd1;
      q_len  <= q_len - 8'd1;
    end
  end

  // Cycle counter for latency checks.
  always @(posedge clock_10KHz) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int         n_vec      = 0;
  int         n_err      = 0;
  logic [7:0] exp_q [$];
  int         nbits      = 0;
  logic [7:0] acc        = 8'd0;
  int         bytes_done = 0;
  int         deq_count  = 0;
  int         deq_cycles [$];
  int         last_acc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge.
  initial begin : monitor
    logic prev_deq, prev_valid, prev_ready, prev_serial;
    prev_deq = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_serial = 1'b0;
    forever begin
      @(negedge clock_10KHz);
      if (reset) begin
        nbits = 0; acc = 8'd0;
        prev_deq = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_serial = 1'b0;
      end else begin
        if (bus.dequeue_out) begin
          deq_count++;
          deq_cycles.push_back(cyc);
          chk("deq_not_back_to_back", {31'd0, prev_deq}, 32'd0);
          chk("deq_only_when_nonempty", {31'd0, (q_len != 8'd0)}, 32'd1);
          if (bytes_done > 0)
            chk("pop_gap_after_last_bit", {31'd0, ((cyc - last_acc) >= 2)}, 32'd1);
        end
        if (bus.valid_out && !prev_valid && deq_cycles.size() > 0)
          chk("pop_to_first_valid", cyc - deq_cycles[$], 32'd3);
        if (bus.valid_out && prev_valid && !prev_ready)
          chk("stall_holds_bit", {31'd0, bus.serial_out}, {31'd0, prev_serial});
        if (bus.valid_out && ready) begin
          acc      = {acc[6:0], bus.serial_out};
          nbits++;
          last_acc = cyc;
        end
        if (bus.done_out) begin
          chk("done_bit_count", nbits, 32'd8);
          chk("done_valid_low", {31'd0, bus.valid_out}, 32'd0);
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none", acc);
          end else begin
            chk("byte", {24'd0, acc}, {24'd0, exp_q.pop_front()});
          end
          nbits = 0;
          bytes_done++;
        end
        prev_deq    = bus.dequeue_out;
        prev_valid  = bus.valid_out;
        prev_ready  = ready;
        prev_serial = bus.serial_out;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Caller is aligned at posedge+1; returns aligned likewise.
  task automatic enq_byte(input logic [7:0] b);
    enq      = 1'b1;
    enq_data = b;
    exp_q.push_back(b);
    @(posedge clock_10KHz); #1;
    enq = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (bytes_done < n && k < budget) begin
      @(posedge clock_10KHz); #1;
      k++;
    end
    chk("wait_bytes_in_time", {31'd0, (bytes_done >= n)}, 32'd1);
  endtask

  task automatic wait_nbits(input int n, input int budget);
    int k = 0;
    while (!(nbits == n && bus.valid_out) && k < budget) begin
      @(posedge clock_10KHz); #1;
      k++;
    end
    chk("wait_bits_in_time", {31'd0, (nbits == n && bus.valid_out)}, 32'd1);
  endtask

  task automatic chk_outputs_low(input string tag);
    chk({tag, "_dequeue"}, {31'd0, bus.dequeue_out}, 32'd0);
    chk({tag, "_serial"},  {31'd0, bus.serial_out},  32'd0);
    chk({tag, "_valid"},   {31'd0, bus.valid_out},   32'd0);
    chk({tag, "_done"},    {31'd0, bus.done_out},    32'd0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int d0;
    int k;
    reset = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clock_10KHz);
    #1;
    chk_outputs_low("reset");

    // Single byte A5 -> bits 1,0,1,0,0,1,0,1
    enq_byte(8'hA5);
    reset = 1'b0;
    wait_bytes(1, 100);
    chk("t1_deq_count", deq_count, 32'd1);
    chk("t1_len_empty", {24'd0, q_len}, 32'd0);

    // Three bytes, then idle with an empty queue
    reset = 1'b1;
    enq_byte(8'h01); enq_byte(8'h80); enq_byte(8'hFF);
    reset = 1'b0;
    wait_bytes(4, 300);
    chk("t2_deq_count", deq_count, 32'd4);
    repeat (20) @(posedge clock_10KHz);
    #1;
    chk("t2_no_pulse_when_empty", deq_count, 32'd4);

    // Enqueue collides with the first pop: dropped, timeout, retry
    reset = 1'b1;
    enq_byte(8'h96);
    reset = 1'b0;
    k = 0;
    do begin
      @(negedge clock_10KHz);
      k++;
    end while (!bus.dequeue_out && k < 20);
    chk("t3_first_pulse_seen", {31'd0, bus.dequeue_out}, 32'd1);
    enq      = 1'b1;
    enq_data = 8'h4E;
    exp_q.push_back(8'h4E);
    @(posedge clock_10KHz); #1;
    enq = 1'b0;
    wait_bytes(6, 300);
    chk("t3_deq_count", deq_count, 32'd7);
    if (deq_cycles.size() >= 6)
      chk("t3_retry_gap", deq_cycles[5] - deq_cycles[4], 32'd5);

    // Downstream stall of 5 cycles at bit 3 of 3C
    reset = 1'b1;
    enq_byte(8'h3C);
    reset = 1'b0;
    wait_nbits(3, 100);
    ready = 1'b0;
    repeat (5) begin
      @(negedge clock_10KHz);
      chk("t4_stall_serial", {31'd0, bus.serial_out}, 32'd1);
      chk("t4_stall_valid",  {31'd0, bus.valid_out},  32'd1);
    end
    @(posedge clock_10KHz); #1;
    ready = 1'b1;
    wait_bytes(7, 300);

    // Enqueue during SHIFT raises len 1 -> 2; no extra pop until DONE
    reset = 1'b1;
    enq_byte(8'h11); enq_byte(8'h22);
    reset = 1'b0;
    wait_nbits(2, 100);
    d0 = deq_count;
    enq_byte(8'hE7);
    chk("t5_len_rose", {24'd0, q_len}, 32'd2);
    wait_bytes(8, 300);
    chk("t5_no_extra_pop", deq_count, d0);
    wait_bytes(10, 400);

    // Reset mid-SHIFT: outputs low at once, current byte lost, rest delivered
    reset = 1'b1;
    enq_byte(8'h5A); enq_byte(8'hC3);
    reset = 1'b0;
    wait_nbits(4, 100);
    reset = 1'b1;
    #1;
    chk_outputs_low("t6_async_reset");
    void'(exp_q.pop_front());
    repeat (2) @(posedge clock_10KHz);
    #1;
    reset = 1'b0;
    wait_bytes(11, 300);
    chk("t6_scoreboard_drained", exp_q.size(), 32'd0);
    chk("t6_len_empty", {24'd0, q_len}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
